// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the registered bus-source arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } bus_arb_state_t;

  localparam int unsigned CODE_W_MAX = 16;
  localparam logic [CODE_W_MAX-1:0] BUS_IDLE_CODE = 16'd0;

  // Source index i drives bus select code i+1; code 0 means nobody drives.
  function automatic logic [CODE_W_MAX-1:0] idx_to_code(input logic [CODE_W_MAX-1:0] idx);
    return idx + 16'd1;
  endfunction

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational winner search: first set request at or after start_i, wrapping past N_SRC-1.
module bus_arb_pick #(
  parameter int unsigned N_SRC = 24,
  parameter int unsigned IDX_W = 5
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             found_o,
  output logic [N_SRC-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o
);

  int unsigned         pos_s;
  logic [IDX_W-1:0]    pos_idx_s;
  logic                hit_s;

  // Scan all offsets from the start index; the first hit latches found_o.
  always_comb begin
    found_o   = 1'b0;
    onehot_o  = {N_SRC{1'b0}};
    idx_o     = {IDX_W{1'b0}};
    pos_s     = 0;
    pos_idx_s = {IDX_W{1'b0}};
    hit_s     = 1'b0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      pos_s     = int'(start_i) + k;
      pos_s     = (pos_s >= N_SRC) ? (pos_s - N_SRC) : pos_s;
      pos_idx_s = IDX_W'(pos_s);
      hit_s     = !found_o && req_i[pos_idx_s];
      onehot_o[pos_idx_s] = onehot_o[pos_idx_s] | hit_s;
      idx_o     = hit_s ? pos_idx_s : idx_o;
      found_o   = found_o | hit_s;
    end
  end

endmodule

// File: rtl/bus_source_arbiter.sv
// Registered bus-source arbiter (fixed priority or round-robin) with grant hold and conflict flag.
// Optional saturating conflict counter enabled by defining BUS_ARB_CONFLICT_CNT_EN.
module bus_source_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned N_SRC   = 24,
  parameter int unsigned CODE_W  = 5,
  parameter bit          RR_MODE = 1'b0
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [N_SRC-1:0]  req,
  input  logic              hold,
  output logic [CODE_W-1:0] grant_code,
  output logic [N_SRC-1:0]  grant_onehot,
  output logic              grant_valid,
  output logic              conflict
`ifdef BUS_ARB_CONFLICT_CNT_EN
  ,
  output logic [7:0]        conflict_count,
  input  logic              conflict_clr
`endif
);

  localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  if ((64'd1 << CODE_W) <= 64'(N_SRC)) begin : g_code_w_check
    $error("bus_source_arbiter: 2**CODE_W must exceed N_SRC");
  end

  bus_arb_state_t      state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [N_SRC-1:0]    onehot_q, onehot_d;
  logic                valid_q, valid_d;
  logic                conflict_q, conflict_d;
  logic [IDX_W-1:0]    last_q, last_d;

  logic [IDX_W-1:0]    start_s;
  logic                win_found_s;
  logic [N_SRC-1:0]    win_onehot_s;
  logic [IDX_W-1:0]    win_idx_s;
  logic [CODE_W_MAX-1:0] win_code_full_s;
  logic [CODE_W-1:0]   win_code_s;
  logic                held_req_s;

  assign start_s = RR_MODE ? ((last_q == IDX_W'(N_SRC - 1)) ? {IDX_W{1'b0}} : last_q + IDX_W'(1))
                           : {IDX_W{1'b0}};

  bus_arb_pick #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i    (req),
    .start_i  (start_s),
    .found_o  (win_found_s),
    .onehot_o (win_onehot_s),
    .idx_o    (win_idx_s)
  );

  assign win_code_full_s = idx_to_code(CODE_W_MAX'(win_idx_s));
  assign win_code_s      = win_code_full_s[CODE_W-1:0];
  assign held_req_s      = |(req & onehot_q);

  // Next-state and next-grant logic; grant fields are always updated together.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    onehot_d   = onehot_q;
    valid_d    = valid_q;
    last_d     = last_q;
    conflict_d = |(req & (req - N_SRC'(1)));
    case (state_q)
      IDLE, GRANT: begin
        if (state_q == GRANT && hold && held_req_s) begin
          state_d = HOLD;
        end else if (win_found_s) begin
          state_d  = GRANT;
          code_d   = win_code_s;
          onehot_d = win_onehot_s;
          valid_d  = 1'b1;
          last_d   = win_idx_s;
        end else begin
          state_d  = IDLE;
          code_d   = BUS_IDLE_CODE[CODE_W-1:0];
          onehot_d = {N_SRC{1'b0}};
          valid_d  = 1'b0;
        end
      end
      HOLD: begin
        if (hold && held_req_s) begin
          state_d = HOLD;
        end else if (win_found_s) begin
          state_d  = GRANT;
          code_d   = win_code_s;
          onehot_d = win_onehot_s;
          valid_d  = 1'b1;
          last_d   = win_idx_s;
        end else begin
          state_d  = IDLE;
          code_d   = BUS_IDLE_CODE[CODE_W-1:0];
          onehot_d = {N_SRC{1'b0}};
          valid_d  = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        code_d   = BUS_IDLE_CODE[CODE_W-1:0];
        onehot_d = {N_SRC{1'b0}};
        valid_d  = 1'b0;
      end
    endcase
  end

  // State and registered grant outputs.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q    <= IDLE;
      code_q     <= BUS_IDLE_CODE[CODE_W-1:0];
      onehot_q   <= {N_SRC{1'b0}};
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
      last_q     <= IDX_W'(N_SRC - 1);
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      onehot_q   <= onehot_d;
      valid_q    <= valid_d;
      conflict_q <= conflict_d;
      last_q     <= last_d;
    end
  end

  assign grant_code   = code_q;
  assign grant_onehot = onehot_q;
  assign grant_valid  = valid_q;
  assign conflict     = conflict_q;

`ifdef BUS_ARB_CONFLICT_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Clear wins over increment; increment tracks the conflict flag being loaded high.
  always_comb begin
    cnt_d = cnt_q;
    if (conflict_clr) begin
      cnt_d = 8'd0;
    end else if (conflict_d && (cnt_q != 8'd255)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Conflict counter register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_count = cnt_q;
`endif

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Directed self-checking bench: fixed-priority and round-robin instances side by side.
module tb_bus_source_arbiter;

  logic        clock;
  logic        clear_n;
  logic [23:0] req_f, req_r;
  logic        hold_f, hold_r;
  logic [4:0]  code_f, code_r;
  logic [23:0] oh_f, oh_r;
  logic        valid_f, valid_r;
  logic        conf_f, conf_r;
`ifdef BUS_ARB_CONFLICT_CNT_EN
  logic [7:0]  cnt_f, cnt_r;
  logic        clr_f, clr_r;
`endif

  int checks   = 0;
  int failures = 0;

  bus_source_arbiter #(.N_SRC(24), .CODE_W(5), .RR_MODE(1'b0)) u_fix (
    .clock        (clock),
    .clear_n      (clear_n),
    .req          (req_f),
    .hold         (hold_f),
    .grant_code   (code_f),
    .grant_onehot (oh_f),
    .grant_valid  (valid_f),
    .conflict     (conf_f)
`ifdef BUS_ARB_CONFLICT_CNT_EN
    ,
    .conflict_count (cnt_f),
    .conflict_clr   (clr_f)
`endif
  );

  bus_source_arbiter #(.N_SRC(24), .CODE_W(5), .RR_MODE(1'b1)) u_rr (
    .clock        (clock),
    .clear_n      (clear_n),
    .req          (req_r),
    .hold         (hold_r),
    .grant_code   (code_r),
    .grant_onehot (oh_r),
    .grant_valid  (valid_r),
    .conflict     (conf_r)
`ifdef BUS_ARB_CONFLICT_CNT_EN
    ,
    .conflict_count (cnt_r),
    .conflict_clr   (clr_r)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear_n = 1'b0;
    req_f = 24'h0; req_r = 24'h0;
    hold_f = 1'b0; hold_r = 1'b0;
`ifdef BUS_ARB_CONFLICT_CNT_EN
    clr_f = 1'b0; clr_r = 1'b0;
`endif
    #12;
    check("rst_code",  32'(code_f),  32'h0);
    check("rst_oh",    32'(oh_f),    32'h0);
    check("rst_valid", 32'(valid_f), 32'h0);
    check("rst_conf",  32'(conf_f),  32'h0);
    check("rst_rr_valid", 32'(valid_r), 32'h0);
    clear_n = 1'b1;
    tick();

    req_f = 24'h000008; tick();
    check("single_code",  32'(code_f),  32'd4);
    check("single_oh",    32'(oh_f),    32'h000008);
    check("single_valid", 32'(valid_f), 32'h1);
    check("single_conf",  32'(conf_f),  32'h0);

    req_f = 24'h0; tick();
    check("release_code",  32'(code_f),  32'd0);
    check("release_valid", 32'(valid_f), 32'h0);
    check("release_oh",    32'(oh_f),    32'h0);

    req_f = 24'h000030; tick();
    check("prio_code", 32'(code_f), 32'd5);
    check("prio_oh",   32'(oh_f),   32'h000010);
    check("prio_conf", 32'(conf_f), 32'h1);

    req_f = 24'h800000; tick();
    check("top_code",  32'(code_f),  32'd24);
    check("top_conf",  32'(conf_f),  32'h0);
    check("top_valid", 32'(valid_f), 32'h1);

    req_f = 24'h000004; tick();
    check("pre_hold_code", 32'(code_f), 32'd3);

    hold_f = 1'b1; req_f = 24'h000007; tick();
    check("hold_enter_code", 32'(code_f), 32'd3);
    check("hold_conf",       32'(conf_f), 32'h1);
    tick();
    check("hold_stay_code", 32'(code_f), 32'd3);
    check("hold_stay_oh",   32'(oh_f),   32'h000004);

    req_f = 24'h000003; tick();
    check("hold_exit_code", 32'(code_f), 32'd1);
    check("hold_exit_oh",   32'(oh_f),   32'h000001);

    req_f = 24'h000004; tick();
    check("regrant_code", 32'(code_f), 32'd3);
    req_f = 24'h000005; tick();
    check("hold2_code", 32'(code_f), 32'd3);
    check("hold2_conf", 32'(conf_f), 32'h1);

    #2;
    clear_n = 1'b0;
    #1;
    check("midhold_rst_code",  32'(code_f),  32'h0);
    check("midhold_rst_oh",    32'(oh_f),    32'h0);
    check("midhold_rst_valid", 32'(valid_f), 32'h0);
    check("midhold_rst_conf",  32'(conf_f),  32'h0);
    hold_f = 1'b0; req_f = 24'h000010;
    #2;
    clear_n = 1'b1;
    tick();
    check("post_rst_code",  32'(code_f),  32'd5);
    check("post_rst_oh",    32'(oh_f),    32'h000010);
    check("post_rst_valid", 32'(valid_f), 32'h1);

    req_r = 24'h000007;
    tick(); check("rr_0", 32'(code_r), 32'd1);
    tick(); check("rr_1", 32'(code_r), 32'd2);
    tick(); check("rr_2", 32'(code_r), 32'd3);
    tick(); check("rr_3", 32'(code_r), 32'd1);
    check("rr_conf", 32'(conf_r), 32'h1);
    req_r = 24'h800001; tick();
    check("rr_next_code", 32'(code_r), 32'd24);
    req_r = 24'h0; tick();
    check("rr_idle_valid", 32'(valid_r), 32'h0);
    check("rr_idle_code",  32'(code_r),  32'd0);

`ifdef BUS_ARB_CONFLICT_CNT_EN
    req_f = 24'h000001; tick();
    check("cnt_start", 32'(cnt_f), 32'd0);
    req_f = 24'h000003;
    for (int i = 0; i < 300; i++) tick();
    check("cnt_sat", 32'(cnt_f), 32'd255);
    clr_f = 1'b1; tick();
    check("cnt_clr", 32'(cnt_f), 32'd0);
    clr_f = 1'b0; tick();
    check("cnt_inc", 32'(cnt_f), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
